// File: rtl/sprite_pkg.sv
// Shared definitions for the animated palette sprite source: animation modes,
// control-word field layout and power-on palette contents.
package sprite_pkg;

    typedef enum logic [1:0] {
        STATIC  = 2'd0,
        LOOP    = 2'd1,
        ONESHOT = 2'd2,
        BLINK   = 2'd3
    } mode_e;

    // Control word is {rate, mode, frame_sel}; offsets below sit above frame_sel.
    localparam int MODE_W       = 2;
    localparam int RATE_W       = 8;
    localparam int CTRL_FIXED_W = MODE_W + RATE_W;
    localparam int MODE_OFS     = 0;
    localparam int RATE_OFS     = MODE_W;

    localparam logic [11:0] PAL_DEF_1 = 12'h100;
    localparam logic [11:0] PAL_DEF_2 = 12'hFF0;
    localparam logic [11:0] PAL_DEF_3 = 12'hFFF;

endpackage

// File: rtl/sprite_ram_lut.sv
// Simple dual-port bitmap RAM: synchronous write, registered read.
// A read of the address being written returns the previous contents.
module sprite_ram_lut #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr_w,
    input  logic [DATA_WIDTH-1:0] i_data_w,
    input  logic [ADDR_WIDTH-1:0] i_addr_r,
    output logic [DATA_WIDTH-1:0] o_data_r
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr_w] <= i_data_w;
        end
        o_data_r <= r_mem[i_addr_r];
    end

endmodule

// File: rtl/anim_sprite_src.sv
// Animated 2-bit palette sprite source: frame animation, blinking and manual
// frame selection stepped by the per-video-frame tick; 2-cycle pixel latency.
module anim_sprite_src
    import sprite_pkg::*;
#(
    parameter int            CD        = 12,
    parameter int            H_BITS    = 4,
    parameter int            V_BITS    = 4,
    parameter int            F_BITS    = 2,
    parameter logic [CD-1:0] KEY_COLOR = '0
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic [10:0]                      i_x,
    input  logic [10:0]                      i_y,
    input  logic [10:0]                      i_x0,
    input  logic [10:0]                      i_y0,
    input  logic                             i_frame_tick,
    input  logic                             i_we,
    input  logic [F_BITS+V_BITS+H_BITS-1:0]  i_addr_w,
    input  logic [1:0]                       i_pixel_in,
    input  logic                             i_pal_we,
    input  logic [1:0]                       i_pal_idx,
    input  logic [CD-1:0]                    i_pal_rgb,
    input  logic                             i_ctrl_we,
    input  logic [F_BITS+CTRL_FIXED_W-1:0]   i_ctrl,
    output logic [CD-1:0]                    o_sprite_rgb,
    output logic                             o_anim_done
);

    localparam int                AW         = F_BITS + V_BITS + H_BITS;
    localparam logic [F_BITS-1:0] LAST_FRAME = '1;

    logic [F_BITS+CTRL_FIXED_W-1:0] r_ctrl;
    logic [F_BITS-1:0]              r_cur_frame;
    logic [RATE_W-1:0]              r_tick_cnt;
    logic                           r_visible;
    logic                           r_anim_done;
    logic [CD-1:0]                  r_pal [4];
    logic                           r_region_d1;
    logic                           r_visible_d1;

    logic [F_BITS-1:0]              w_frame_sel;
    logic [F_BITS-1:0]              w_next_frame;
    mode_e                          w_mode;
    logic [RATE_W-1:0]              w_rate;
    logic [11:0]                    w_xr;
    logic [11:0]                    w_yr;
    logic                           w_in_region;
    logic [AW-1:0]                  w_addr_r;
    logic [1:0]                     w_code;

    assign w_frame_sel = r_ctrl[F_BITS-1:0];
    assign w_mode      = mode_e'(r_ctrl[F_BITS+MODE_OFS +: MODE_W]);
    assign w_rate      = r_ctrl[F_BITS+RATE_OFS +: RATE_W];

    // One-shot parks on the last frame; loop wraps naturally.
    assign w_next_frame = (w_mode == ONESHOT && r_cur_frame == LAST_FRAME)
                        ? r_cur_frame : r_cur_frame + F_BITS'(1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ctrl      <= '0;
            r_cur_frame <= '0;
            r_tick_cnt  <= '0;
            r_visible   <= 1'b1;
            r_anim_done <= 1'b0;
        end else if (i_ctrl_we) begin
            r_ctrl      <= i_ctrl;
            r_cur_frame <= i_ctrl[F_BITS-1:0];
            r_tick_cnt  <= '0;
            r_visible   <= 1'b1;
            r_anim_done <= 1'b0;
        end else if (i_frame_tick) begin
            if (r_tick_cnt == w_rate) begin
                r_tick_cnt <= '0;
                case (w_mode)
                    LOOP:    r_cur_frame <= w_next_frame;
                    ONESHOT: begin
                        r_cur_frame <= w_next_frame;
                        if (w_next_frame == LAST_FRAME) r_anim_done <= 1'b1;
                    end
                    BLINK:   r_visible <= ~r_visible;
                    default: r_cur_frame <= w_frame_sel;
                endcase
            end else begin
                r_tick_cnt <= r_tick_cnt + RATE_W'(1);
            end
        end
    end

    // Entry 0 stays at KEY_COLOR so code 0 decodes transparent without a special case.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pal[0] <= KEY_COLOR;
            r_pal[1] <= CD'(PAL_DEF_1);
            r_pal[2] <= CD'(PAL_DEF_2);
            r_pal[3] <= CD'(PAL_DEF_3);
        end else if (i_pal_we && i_pal_idx != 2'd0) begin
            r_pal[i_pal_idx] <= i_pal_rgb;
        end
    end

    assign w_xr        = {1'b0, i_x} - {1'b0, i_x0};
    assign w_yr        = {1'b0, i_y} - {1'b0, i_y0};
    assign w_in_region = (w_xr[11:H_BITS] == '0) && (w_yr[11:V_BITS] == '0);
    assign w_addr_r    = {r_cur_frame, w_yr[V_BITS-1:0], w_xr[H_BITS-1:0]};

    sprite_ram_lut #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (2)
    ) u_ram (
        .i_clk    (i_clk),
        .i_we     (i_we && !i_reset),
        .i_addr_w (i_addr_w),
        .i_data_w (i_pixel_in),
        .i_addr_r (w_addr_r),
        .o_data_r (w_code)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_region_d1  <= 1'b0;
            r_visible_d1 <= 1'b0;
            o_sprite_rgb <= KEY_COLOR;
        end else begin
            r_region_d1  <= w_in_region;
            r_visible_d1 <= r_visible;
            o_sprite_rgb <= (r_region_d1 && r_visible_d1) ? r_pal[w_code] : KEY_COLOR;
        end
    end

    assign o_anim_done = r_anim_done;

endmodule

// File: tb/tb_anim_sprite_src.sv
// Randomized self-checking bench for anim_sprite_src against a behavioural model
// that derives frame/visibility from the tick count since the last ctrl write.
module tb_anim_sprite_src;
    import sprite_pkg::*;

    localparam logic [11:0] KEY = 12'h000;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [10:0] i_x, i_y, i_x0, i_y0;
    logic        i_frame_tick, i_we, i_pal_we, i_ctrl_we;
    logic [9:0]  i_addr_w;
    logic [1:0]  i_pixel_in, i_pal_idx;
    logic [11:0] i_pal_rgb;
    logic [11:0] i_ctrl;
    logic [11:0] o_sprite_rgb;
    logic        o_anim_done;

    anim_sprite_src dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_x          (i_x),
        .i_y          (i_y),
        .i_x0         (i_x0),
        .i_y0         (i_y0),
        .i_frame_tick (i_frame_tick),
        .i_we         (i_we),
        .i_addr_w     (i_addr_w),
        .i_pixel_in   (i_pixel_in),
        .i_pal_we     (i_pal_we),
        .i_pal_idx    (i_pal_idx),
        .i_pal_rgb    (i_pal_rgb),
        .i_ctrl_we    (i_ctrl_we),
        .i_ctrl       (i_ctrl),
        .o_sprite_rgb (o_sprite_rgb),
        .o_anim_done  (o_anim_done)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int mem [1024];
    int pal [4];
    int m_mode, m_rate, m_fsel, m_n;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_steps();
        return m_n / (m_rate + 1);
    endfunction

    function automatic int m_frame();
        int s = m_steps();
        case (m_mode)
            1:       return (m_fsel + s) % 4;
            2:       return (m_fsel + s > 3) ? 3 : m_fsel + s;
            default: return m_fsel;
        endcase
    endfunction

    function automatic bit m_vis();
        return (m_mode == 3) ? ((m_steps() % 2) == 0) : 1'b1;
    endfunction

    function automatic bit m_done();
        int s = m_steps();
        return (m_mode == 2) && (s >= 1) && (m_fsel + s >= 3);
    endfunction

    function automatic int exp_pix(int x, int y);
        int xr = x - int'(i_x0);
        int yr = y - int'(i_y0);
        int code;
        if (xr < 0 || xr > 15 || yr < 0 || yr > 15) return int'(KEY);
        code = mem[m_frame() * 256 + yr * 16 + xr];
        if (code == 0 || !m_vis()) return int'(KEY);
        return pal[code];
    endfunction

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic reset_model();
        pal[0] = int'(KEY); pal[1] = 'h100; pal[2] = 'hFF0; pal[3] = 'hFFF;
        m_mode = 0; m_rate = 0; m_fsel = 0; m_n = 0;
    endtask

    task automatic wr_bm(input int addr, input int code);
        i_we = 1'b1; i_addr_w = 10'(addr); i_pixel_in = 2'(code);
        cyc();
        i_we = 1'b0;
        mem[addr] = code;
    endtask

    task automatic wr_pal(input int idx, input int rgb);
        i_pal_we = 1'b1; i_pal_idx = 2'(idx); i_pal_rgb = 12'(rgb);
        cyc();
        i_pal_we = 1'b0;
        if (idx != 0) pal[idx] = rgb;
    endtask

    task automatic wr_ctrl(input int mode, input int rate, input int fsel);
        i_ctrl = {8'(rate), 2'(mode), 2'(fsel)}; i_ctrl_we = 1'b1;
        cyc();
        i_ctrl_we = 1'b0;
        m_mode = mode; m_rate = rate; m_fsel = fsel; m_n = 0;
    endtask

    task automatic pulse_tick();
        i_frame_tick = 1'b1;
        cyc();
        i_frame_tick = 1'b0;
        m_n++;
    endtask

    task automatic probe(input string tag, input int dx, input int dy);
        int x = int'(i_x0) + dx;
        int y = int'(i_y0) + dy;
        int e = exp_pix(x, y);
        i_x = 11'(x); i_y = 11'(y);
        cyc();
        cyc();
        check_eq(tag, 32'(o_sprite_rgb), 32'(e));
    endtask

    task automatic probe_rand(input string tag, input int n);
        for (int k = 0; k < n; k++)
            probe(tag, int'($urandom_range(0, 21)) - 3, int'($urandom_range(0, 21)) - 3);
    endtask

    task automatic new_origin();
        i_x0 = 11'($urandom_range(20, 2000));
        i_y0 = 11'($urandom_range(20, 2000));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b1; i_x = '0; i_y = '0; i_x0 = 11'd100; i_y0 = 11'd50;
        i_frame_tick = 1'b0; i_we = 1'b0; i_addr_w = '0; i_pixel_in = '0;
        i_pal_we = 1'b0; i_pal_idx = '0; i_pal_rgb = '0; i_ctrl_we = 1'b0; i_ctrl = '0;
        reset_model();
        repeat (3) cyc();
        i_reset = 1'b0;
        check_eq("reset_rgb", 32'(o_sprite_rgb), 32'(KEY));
        check_eq("reset_done", 32'(o_anim_done), 32'd0);

        for (int a = 0; a < 1024; a++) wr_bm(a, int'($urandom_range(0, 3)));
        for (int f = 0; f < 4; f++) begin
            wr_bm(f * 256 + 0, (f & 1) + 1);
            wr_bm(f * 256 + 1, ((f >> 1) & 1) + 1);
            wr_bm(f * 256 + 255, 0);
        end
        wr_bm(83, 2);

        probe("basic_ff0", 3, 5);
        check_eq("basic_const", 32'(o_sprite_rgb), 32'h0FF0);
        probe("xr_m1", -1, 5);
        probe("xr_16", 16, 5);
        probe("yr_m1", 3, -1);
        probe("yr_16", 3, 16);
        probe("corner", 15, 15);

        wr_pal(2, 'h0F0);
        probe("pal_write", 3, 5);
        check_eq("pal_const", 32'(o_sprite_rgb), 32'h00F0);
        wr_pal(0, 'hABC);
        probe("pal0_noop", 15, 15);
        probe_rand("static_f0", 6);

        for (int r = 0; r < 3; r++) begin
            new_origin();
            wr_ctrl(0, $urandom_range(0, 3), $urandom_range(0, 3));
            probe_rand("static_rand", 6);
        end

        new_origin();
        wr_ctrl(1, 2, 1);
        for (int t = 0; t < 12; t++) begin
            probe("loop_id0", 0, 0);
            probe("loop_id1", 1, 0);
            check_eq("loop_done", 32'(o_anim_done), 32'(m_done()));
            pulse_tick();
        end

        wr_ctrl(2, 0, 2);
        for (int t = 0; t < 4; t++) begin
            probe("oneshot_id0", 0, 0);
            probe("oneshot_id1", 1, 0);
            check_eq("oneshot_done", 32'(o_anim_done), 32'(m_done()));
            pulse_tick();
        end
        check_eq("oneshot_done_end", 32'(o_anim_done), 32'(m_done()));
        wr_ctrl(2, 0, 0);
        check_eq("done_clear", 32'(o_anim_done), 32'd0);

        wr_ctrl(3, 1, $urandom_range(0, 3));
        for (int t = 0; t < 8; t++) begin
            probe("blink", 0, 0);
            pulse_tick();
        end
        pulse_tick();
        pulse_tick();
        probe("blink_off", 0, 0);
        i_ctrl = {8'd1, 2'd3, 2'(m_fsel)}; i_ctrl_we = 1'b1; i_frame_tick = 1'b1;
        cyc();
        i_ctrl_we = 1'b0; i_frame_tick = 1'b0;
        m_n = 0;
        probe("collide_vis", 0, 0);
        pulse_tick();
        probe("collide_t1", 0, 0);
        pulse_tick();
        probe("collide_t2", 0, 0);

        for (int r = 0; r < 6; r++) begin
            int nt;
            new_origin();
            if ($urandom_range(0, 1) == 1) wr_pal($urandom_range(0, 3), $urandom_range(0, 4095));
            wr_ctrl($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            nt = $urandom_range(0, 9);
            for (int t = 0; t < nt; t++) pulse_tick();
            probe("rand_id0", 0, 0);
            probe("rand_id1", 1, 0);
            probe_rand("rand_px", 3);
            check_eq("rand_done", 32'(o_anim_done), 32'(m_done()));
        end

        wr_ctrl(1, 0, 1);
        pulse_tick();
        wr_pal(3, 'hABC);
        probe("pre_reset_f2", 0, 0);
        i_reset = 1'b1;
        i_pal_we = 1'b1; i_pal_idx = 2'd1; i_pal_rgb = 12'h555;
        i_we = 1'b1; i_addr_w = 10'd0; i_pixel_in = 2'd3;
        cyc();
        i_reset = 1'b0; i_pal_we = 1'b0; i_we = 1'b0;
        reset_model();
        check_eq("rst_rgb", 32'(o_sprite_rgb), 32'(KEY));
        check_eq("rst_done", 32'(o_anim_done), 32'd0);
        probe("rst_id0", 0, 0);
        check_eq("rst_pal1", 32'(o_sprite_rgb), 32'h0100);
        probe("rst_id1", 1, 0);
        probe_rand("rst_px", 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/anim_sprite_src.md
# anim_sprite_src

Parametrised, animated palette sprite source for the video pixel pipeline. It produces one sprite's colour for the current scan position (x, y) relative to an origin (x0, y0). Each pixel is a 2-bit code from a multi-frame bitmap RAM, decoded through a CPU-programmable 4-entry palette. It adds frame animation (loop or one-shot), blinking and manual frame selection, driven by a per-video-frame tick. It sits beside the other sprite sources and feeds the layer mux, which treats KEY_COLOR as transparent.

## Interface
- CD, 12, colour depth of palette entries and output
- H_BITS, 4, log2 sprite width (H_SIZE = 2^H_BITS)
- V_BITS, 4, log2 sprite height (V_SIZE = 2^V_BITS)
- F_BITS, 2, log2 frame count (FRAMES = 2^F_BITS)
- KEY_COLOR, 12'h000, transparent colour; output outside the sprite and for code 0
- clk  in  1  system/pixel clock; one clock only
- reset  in  1  synchronous, active-high reset
- x, y  in  11 each  current scan position
- x0, y0  in  11 each  sprite origin (top-left)
- frame_tick  in  1  one-cycle pulse per video frame
- we  in  1  bitmap write strobe
- addr_w  in  F_BITS+V_BITS+H_BITS  write address {frame, row, col}
- pixel_in  in  2  bitmap code to write
- pal_we  in  1  palette write strobe
- pal_idx  in  2  palette entry index (entry 0 is ignored; code 0 is always KEY_COLOR)
- pal_rgb  in  CD  palette write data
- ctrl_we  in  1  control register write strobe
- ctrl  in  F_BITS+10  {rate[7:0], mode[1:0], frame_sel[F_BITS-1:0]}
- sprite_rgb  out  CD  sprite colour, registered
- anim_done  out  1  high after a one-shot sequence reaches its last frame; cleared on ctrl write

## Operation
- Relative position: xr = x − x0, yr = y − y0, computed at 12-bit signed width. in_region holds when 0 ≤ xr < H_SIZE and 0 ≤ yr < V_SIZE.
- Read address = {cur_frame, yr[V_BITS-1:0], xr[H_BITS-1:0]}.
- Modes:
  - STATIC (0): cur_frame = frame_sel.
  - LOOP (1): advance cur_frame every rate+1 frame_ticks; wraps FRAMES−1 → 0.
  - ONESHOT (2): advances like LOOP but stops on FRAMES−1 and sets anim_done.
  - BLINK (3): cur_frame = frame_sel; visibility toggles every rate+1 frame_ticks; while invisible, output is KEY_COLOR.
- Tick counter: counts frame_ticks from 0 up to rate. At the terminal count it resets to 0 and issues a step, which either advances the frame or toggles visibility.
- rate = 0 steps on every tick.
- A ctrl write:
  - loads the register;
  - clears the tick counter and anim_done;
  - sets visible = 1;
  - sets cur_frame = frame_sel in every mode. LOOP and ONESHOT start from frame_sel.
- If ctrl_we and frame_tick arrive in the same cycle, ctrl_we wins and that tick is dropped.
- cur_frame, the tick counter and visibility update only on frame_tick. They are therefore stable within a frame, so there is no mid-frame tearing.
- Palette write: entries 1..3 are updated on pal_we. pal_idx = 0 is a no-op.
- Simultaneous bitmap write and read of the same address: the read returns the old data.

## Timing
- Latency is 2 cycles from (x, y) to sprite_rgb:
  - cycle 1: RAM registered read; in_region and visible are delayed one stage to stay aligned with it;
  - cycle 2: palette decode and output register.
- Palette, ctrl and bitmap writes take effect for reads issued on the following cycle.
- Reset values:
  - sprite_rgb = KEY_COLOR;
  - anim_done = 0;
  - ctrl = 0 (STATIC, frame 0, rate 0);
  - cur_frame = 0, tick counter = 0, visible = 1;
  - palette = {KEY_COLOR, 12'h100, 12'hFF0, 12'hFFF};
  - pipeline valid/region flags = 0.
- Bitmap RAM is not reset.
- Reset mid-animation returns to these values on the next edge. Writes in the reset cycle are ignored.

## Structure
- Shared package sprite_pkg holds:
  - the mode enum: STATIC, LOOP, ONESHOT, BLINK;
  - the ctrl field widths and offsets;
  - the default palette constants.
- One sub-module, sprite_ram_lut: simple dual-port RAM with synchronous write and registered read. Parameters ADDR_WIDTH and DATA_WIDTH (set to 2); it infers BRAM or distributed RAM.

## Test plan
- Reset, then (x, y) = (x0+3, y0+5) with code 2 written at {0, 5, 3} → sprite_rgb = 12'hFF0 exactly 2 cycles later. Positions at xr = −1 and xr = 16 → KEY_COLOR.
- Palette write pal_idx = 2, pal_rgb = 12'h0F0 → the same pixel becomes 12'h0F0. A write with pal_idx = 0 leaves code-0 pixels at KEY_COLOR.
- LOOP, rate = 2, frame_sel = 1 → cur_frame steps 1, 2, 3, 0 on every 3rd frame_tick. Verify using distinct per-frame pixel codes.
- ONESHOT, rate = 0, frame_sel = 2 → frames 2, 3, then hold at 3. anim_done rises on reaching 3 and clears on the next ctrl write.
- BLINK, rate = 1 → the sprite is visible for 2 ticks, then KEY_COLOR for 2 ticks, repeating. ctrl_we issued in the same cycle as frame_tick → counter is 0 and visible = 1.
- Assert reset during LOOP at frame 2 → the next cycle shows frame 0, sprite_rgb = KEY_COLOR, and the palette is back at its defaults.
